divider_8_port_master: RTL and testbench
========================================

# divider_8_port_master

Hardware initiator for the PicoBlaze-style I/O port bus used by the 8-bit divider board design. It drives port_id, out_port, read_strobe, write_strobe and k_write_strobe exactly as the KCPSM6 does, and samples in_port. It is a drop-in replacement for the processor plus program ROM: it reads operands and Start/Ack through the existing in_port mux and writes Quotient, Remainder and state flags to the existing output registers. The divide is repeated subtraction.

## Interface
- Parameters: none (port addresses and codes are package constants).
- board_clk  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high.
- port_id  out  8  port address; valid for a whole transaction.
- out_port  out  8  write data; valid for a whole write transaction.
- write_strobe  out  1  one-cycle pulse qualifying a general write.
- k_write_strobe  out  1  one-cycle pulse qualifying a status (OUTPUTK-style) write.
- read_strobe  out  1  one-cycle pulse; in_port is sampled at the clock edge ending this cycle.
- in_port  in  8  read data from the combinational responder mux.

## Operation
- Port map:
  - Read 0x00 = Xin; read 0x01 = Yin; read 0x03 = {6'b0, Start, Ack}.
  - Write (write_strobe) 0x00 = Quotient; 0x02 = Remainder.
  - Status (k_write_strobe) 0x01 = {4'b0, Qd, Qc, Qi, Done}.
  - Status codes: INI = 0x02, CMP = 0x04, DON = 0x09.
- Main FSM states and behaviour:
  - RST_ENTRY: after Reset, write status INI, then go to INITIAL.
  - INITIAL: poll read 0x03 back to back.
    - If bit1 (Start) = 1: read 0x00 into X, read 0x01 into Y, set Q = 0, R = X, write status CMP, go to COMPUTE.
  - COMPUTE: one step per cycle, no bus activity.
    - If R >= Y: R <= R - Y, Q <= Q + 1.
    - Otherwise go to WR_RES.
  - WR_RES: write Q to 0x00, write R to 0x02, write status DON, go to DONE.
  - DONE: poll read 0x03.
    - If bit0 (Ack) = 1: write status INI, go to INITIAL.
- Arithmetic: Q and R are 8-bit unsigned. The comparison is unsigned and R never underflows. Q cannot overflow when Y >= 1.
- Simultaneous events:
  - Start and Ack both high in DONE: Ack wins.
  - Start still held on the first INITIAL poll starts a new divide (level-sensitive, as in the board design).
  - Start or Ack in any non-polling state is ignored.
- Reset mid-operation: everything is aborted immediately, and any strobe in flight drops asynchronously.

## Timing
- Reset values: port_id = 0x00, out_port = 0x00, all strobes = 0, X = Y = Q = R = 0.
- Every bus transaction takes exactly 2 cycles:
  - Setup cycle: port_id (and out_port for writes) driven, strobes low.
  - Strobe cycle: exactly one strobe high.
- Transactions are issued back to back. At most one strobe is high in any cycle.
- port_id and out_port hold their last values between transactions.
- Latency:
  - Start sampled high → CMP status strobe: 6 cycles.
  - COMPUTE occupies Q_final + 1 cycles.
  - Last COMPUTE cycle → DON status strobe: 6 cycles.
- Poll period is 2 cycles.

## Configuration
- DIV_ZERO_GUARD_EN defined: if Y = 0x00 when COMPUTE is entered, COMPUTE is skipped. WR_RES then writes Q = 0xFF and R = X.
- DIV_ZERO_GUARD_EN undefined: Y = 0x00 leaves the block in COMPUTE indefinitely, with no bus activity, until Reset. This matches the plain repeated-subtraction semantics.

## Structure
- Package divider_port_pkg holds:
  - the port address constants (PORT_X, PORT_Y, PORT_BTN, PORT_QUO, PORT_REM, PORT_STAT);
  - the status codes INI, CMP and DON;
  - the main-FSM state enum.
- Sub-module port_bus_sequencer:
  - Accepts req / kind (read, write, kwrite) / addr / wdata from the main FSM.
  - Runs the 2-cycle transaction and returns a one-cycle done pulse together with rdata.
  - The main FSM never drives strobes directly.

## Test plan
- Reset released, Start = 0:
  - Required: k_write_strobe with port_id 0x01 and out_port 0x02.
  - Then read_strobe on port 0x03 every 2 cycles.
- X = 0x64, Y = 0x07, Start pulse:
  - Required order: reads of 0x00 and 0x01, then status 0x04, then 15 COMPUTE cycles.
  - Then writes 0x0E to 0x00 and 0x02 to 0x02, then status 0x09.
- X = 0x05, Y = 0x09: Q = 0x00, R = 0x05, with exactly 1 COMPUTE cycle.
- In DONE, Start and Ack asserted together:
  - Required: status 0x02 written.
  - Then, with Start still high, the next poll launches a new divide.
- Y = 0x00 with DIV_ZERO_GUARD_EN: writes 0xFF and X.
  - Without the macro: no strobe for 1000 cycles.
- Reset asserted during COMPUTE and during a strobe cycle:
  - Required: strobes drop asynchronously and outputs take their reset values.
  - After release, the RST_ENTRY status write recurs.

Source files
------------

// File: rtl/divider_port_pkg.sv
// Shared constants, bus payload and state types for the divider port-bus initiator.
package divider_port_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] PORT_X    = 8'h00;
    localparam logic [DATA_W-1:0] PORT_Y    = 8'h01;
    localparam logic [DATA_W-1:0] PORT_BTN  = 8'h03;
    localparam logic [DATA_W-1:0] PORT_QUO  = 8'h00;
    localparam logic [DATA_W-1:0] PORT_REM  = 8'h02;
    localparam logic [DATA_W-1:0] PORT_STAT = 8'h01;

    // Status byte layout {4'b0, Qd, Qc, Qi, Done}
    localparam logic [DATA_W-1:0] INI = 8'h02;
    localparam logic [DATA_W-1:0] CMP = 8'h04;
    localparam logic [DATA_W-1:0] DON = 8'h09;

    localparam int unsigned BTN_START = 1;
    localparam int unsigned BTN_ACK   = 0;

    typedef enum logic [1:0] {
        BUS_READ,
        BUS_WRITE,
        BUS_KWRITE
    } bus_kind_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE
    } bus_phase_e;

    typedef enum logic [3:0] {
        ST_RST_ENTRY,
        ST_INITIAL,
        ST_RD_X,
        ST_RD_Y,
        ST_WR_CMP,
        ST_COMPUTE,
        ST_WR_QUO,
        ST_WR_REM,
        ST_WR_DON,
        ST_DONE
    } main_state_e;

    typedef struct packed {
        bus_kind_e          kind;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/port_bus_sequencer.sv
// Runs one 2-cycle port transaction (setup, strobe); accepts the next request
// during the strobe cycle so transactions can run back to back.
module port_bus_sequencer
    import divider_port_pkg::*;
(
    input  logic              board_clk,
    input  logic              Reset,
    input  logic              req,
    input  bus_req_t          txn,
    input  logic [DATA_W-1:0] in_port,
    output logic              idle_c,
    output logic              done_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic [DATA_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    output logic              read_strobe,
    output logic              write_strobe,
    output logic              k_write_strobe
);

    bus_phase_e        phase, phase_d;
    bus_kind_e         kind_q, kind_d;
    logic [DATA_W-1:0] port_id_d, out_port_d;
    logic              rs_d, ws_d, ks_d;

    // Registered bus outputs; async reset drops any strobe in flight
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            phase          <= PH_IDLE;
            kind_q         <= BUS_READ;
            port_id        <= '0;
            out_port       <= '0;
            read_strobe    <= 1'b0;
            write_strobe   <= 1'b0;
            k_write_strobe <= 1'b0;
        end else begin
            phase          <= phase_d;
            kind_q         <= kind_d;
            port_id        <= port_id_d;
            out_port       <= out_port_d;
            read_strobe    <= rs_d;
            write_strobe   <= ws_d;
            k_write_strobe <= ks_d;
        end
    end

    always_comb begin
        phase_d    = phase;
        kind_d     = kind_q;
        port_id_d  = port_id;
        out_port_d = out_port;
        rs_d       = 1'b0;
        ws_d       = 1'b0;
        ks_d       = 1'b0;
        case (phase)
            PH_SETUP: begin
                phase_d = PH_STROBE;
                rs_d    = (kind_q == BUS_READ);
                ws_d    = (kind_q == BUS_WRITE);
                ks_d    = (kind_q == BUS_KWRITE);
            end
            default: begin
                if (req) begin
                    phase_d   = PH_SETUP;
                    kind_d    = txn.kind;
                    port_id_d = txn.addr;
                    if (txn.kind != BUS_READ) out_port_d = txn.wdata;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
        endcase
    end

    assign idle_c  = (phase == PH_IDLE);
    assign done_c  = (phase == PH_STROBE);
    assign rdata_c = in_port;

endmodule

// File: rtl/divider_8_port_master.sv
// Port-bus initiator for the 8-bit divider board: polls Start/Ack, reads X/Y,
// divides by repeated subtraction and writes results. Option: DIV_ZERO_GUARD_EN.
module divider_8_port_master
    import divider_port_pkg::*;
(
    input  logic              board_clk,
    input  logic              Reset,
    output logic [DATA_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    output logic              write_strobe,
    output logic              k_write_strobe,
    output logic              read_strobe,
    input  logic [DATA_W-1:0] in_port
);

    main_state_e       state, next_state;
    logic [DATA_W-1:0] y, q, r;
    logic              load_r, load_y, step;
    logic              req;
    bus_req_t          txn;
    logic              seq_idle_c, seq_done_c;
    logic [DATA_W-1:0] rdata_c;

    port_bus_sequencer u_seq (
        .board_clk      (board_clk),
        .Reset          (Reset),
        .req            (req),
        .txn            (txn),
        .in_port        (in_port),
        .idle_c         (seq_idle_c),
        .done_c         (seq_done_c),
        .rdata_c        (rdata_c),
        .port_id        (port_id),
        .out_port       (out_port),
        .read_strobe    (read_strobe),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe)
    );

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state <= ST_RST_ENTRY;
        else       state <= next_state;
    end

    // Next state plus the request for the transaction of the state being entered
    always_comb begin
        next_state = state;
        load_r     = 1'b0;
        load_y     = 1'b0;
        step       = 1'b0;
        req        = 1'b0;
        txn        = '{kind: BUS_READ, addr: PORT_BTN, wdata: '0};
        case (state)
            ST_RST_ENTRY: if (seq_done_c) next_state = ST_INITIAL;
            ST_INITIAL:   if (seq_done_c && rdata_c[BTN_START]) next_state = ST_RD_X;
            ST_RD_X: if (seq_done_c) begin
                load_r     = 1'b1;
                next_state = ST_RD_Y;
            end
            ST_RD_Y: if (seq_done_c) begin
                load_y     = 1'b1;
                next_state = ST_WR_CMP;
            end
            ST_WR_CMP: if (seq_done_c) begin
`ifdef DIV_ZERO_GUARD_EN
                next_state = (y == '0) ? ST_WR_QUO : ST_COMPUTE;
`else
                next_state = ST_COMPUTE;
`endif
            end
            ST_COMPUTE: begin
                if (r >= y) step = 1'b1;
                else        next_state = ST_WR_QUO;
            end
            ST_WR_QUO: if (seq_done_c) next_state = ST_WR_REM;
            ST_WR_REM: if (seq_done_c) next_state = ST_WR_DON;
            ST_WR_DON: if (seq_done_c) next_state = ST_DONE;
            ST_DONE:   if (seq_done_c && rdata_c[BTN_ACK]) next_state = ST_RST_ENTRY;
            default:   next_state = ST_RST_ENTRY;
        endcase

        req = (seq_idle_c || seq_done_c) && (next_state != ST_COMPUTE);
        case (next_state)
            ST_RST_ENTRY: txn = '{kind: BUS_KWRITE, addr: PORT_STAT, wdata: INI};
            ST_RD_X:      txn = '{kind: BUS_READ,   addr: PORT_X,    wdata: '0};
            ST_RD_Y:      txn = '{kind: BUS_READ,   addr: PORT_Y,    wdata: '0};
            ST_WR_CMP:    txn = '{kind: BUS_KWRITE, addr: PORT_STAT, wdata: CMP};
            ST_WR_QUO:    txn = '{kind: BUS_WRITE,  addr: PORT_QUO,  wdata: q};
            ST_WR_REM:    txn = '{kind: BUS_WRITE,  addr: PORT_REM,  wdata: r};
            ST_WR_DON:    txn = '{kind: BUS_KWRITE, addr: PORT_STAT, wdata: DON};
            default:      txn = '{kind: BUS_READ,   addr: PORT_BTN,  wdata: '0};
        endcase
    end

    // Operand and result registers; R is loaded straight from X
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            y <= '0;
            q <= '0;
            r <= '0;
        end else begin
            if (load_r) begin
                r <= rdata_c;
                q <= '0;
            end
            if (load_y) begin
                y <= rdata_c;
`ifdef DIV_ZERO_GUARD_EN
                if (rdata_c == '0) q <= 8'hFF;
`endif
            end
            if (step) begin
                r <= r - y;
                q <= q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_divider_8_port_master.sv
// Directed bench for divider_8_port_master with a behavioural in_port responder.
module tb_divider_8_port_master;

    logic       board_clk = 1'b0;
    logic       Reset;
    logic [7:0] port_id, out_port, in_port;
    logic       write_strobe, k_write_strobe, read_strobe;
    logic [7:0] xin, yin;
    logic       start, ack;
    int         checks = 0;
    int         errors = 0;
    int         viol   = 0;

    localparam logic [2:0] K_RD = 3'b100;
    localparam logic [2:0] K_WR = 3'b010;
    localparam logic [2:0] K_KW = 3'b001;

    divider_8_port_master dut (
        .board_clk      (board_clk),
        .Reset          (Reset),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .in_port        (in_port)
    );

    always #5 board_clk = ~board_clk;

    always_comb begin
        case (port_id)
            8'h00:   in_port = xin;
            8'h01:   in_port = yin;
            8'h03:   in_port = {6'b0, start, ack};
            default: in_port = 8'h00;
        endcase
    end

    always @(negedge board_clk)
        if ((32'(read_strobe) + 32'(write_strobe) + 32'(k_write_strobe)) > 32'd1) viol++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int budget, output int cyc, output logic [2:0] s);
        cyc = 0;
        s   = 3'b000;
        while (cyc < budget && s == 3'b000) begin
            @(negedge board_clk);
            cyc++;
            s = {read_strobe, write_strobe, k_write_strobe};
        end
    endtask

    task automatic expect_txn(input string tag, input logic [2:0] kind, input logic [7:0] port,
                              input logic [7:0] data, input int lat);
        int         cyc;
        logic [2:0] s;
        wait_strobe(2000, cyc, s);
        check({tag, "/strobe"}, 32'(s), 32'(kind));
        check({tag, "/port"}, 32'(port_id), 32'(port));
        if (kind != K_RD) check({tag, "/data"}, 32'(out_port), 32'(data));
        check({tag, "/latency"}, 32'(cyc), 32'(lat));
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, 32'({port_id, out_port, read_strobe, write_strobe, k_write_strobe}), 32'd0);
    endtask

    initial begin
        int         cyc;
        logic [2:0] s;
        Reset = 1'b1;
        xin = 8'h00; yin = 8'h00; start = 1'b0; ack = 1'b0;
        repeat (2) @(negedge board_clk);
        check_reset_values("reset_values");
        Reset = 1'b0;

        expect_txn("ini",   K_KW, 8'h01, 8'h02, 2);
        expect_txn("poll0", K_RD, 8'h03, 8'h00, 2);
        expect_txn("poll1", K_RD, 8'h03, 8'h00, 2);

        // 100 / 7 = 14 r 2
        xin = 8'h64; yin = 8'h07; start = 1'b1;
        expect_txn("a_rdx", K_RD, 8'h00, 8'h00, 2);
        start = 1'b0;
        expect_txn("a_rdy", K_RD, 8'h01, 8'h00, 2);
        expect_txn("a_cmp", K_KW, 8'h01, 8'h04, 2);
        expect_txn("a_quo", K_WR, 8'h00, 8'h0E, 17);
        expect_txn("a_rem", K_WR, 8'h02, 8'h02, 2);
        expect_txn("a_don", K_KW, 8'h01, 8'h09, 2);
        expect_txn("a_pol", K_RD, 8'h03, 8'h00, 2);

        ack = 1'b1;
        expect_txn("a_ack", K_KW, 8'h01, 8'h02, 2);
        ack = 1'b0;
        expect_txn("a_idl", K_RD, 8'h03, 8'h00, 2);

        // 5 / 9 = 0 r 5, single compute cycle
        xin = 8'h05; yin = 8'h09; start = 1'b1;
        expect_txn("b_rdx", K_RD, 8'h00, 8'h00, 2);
        start = 1'b0;
        expect_txn("b_rdy", K_RD, 8'h01, 8'h00, 2);
        expect_txn("b_cmp", K_KW, 8'h01, 8'h04, 2);
        expect_txn("b_quo", K_WR, 8'h00, 8'h00, 3);
        expect_txn("b_rem", K_WR, 8'h02, 8'h05, 2);
        expect_txn("b_don", K_KW, 8'h01, 8'h09, 2);
        expect_txn("b_pol", K_RD, 8'h03, 8'h00, 2);

        // Start and Ack together in DONE: Ack wins, held Start relaunches; 12 / 4 = 3 r 0
        xin = 8'h0C; yin = 8'h04; start = 1'b1; ack = 1'b1;
        expect_txn("c_ack", K_KW, 8'h01, 8'h02, 2);
        ack = 1'b0;
        expect_txn("c_pol", K_RD, 8'h03, 8'h00, 2);
        expect_txn("c_rdx", K_RD, 8'h00, 8'h00, 2);
        start = 1'b0;
        expect_txn("c_rdy", K_RD, 8'h01, 8'h00, 2);
        expect_txn("c_cmp", K_KW, 8'h01, 8'h04, 2);
        expect_txn("c_quo", K_WR, 8'h00, 8'h03, 6);
        expect_txn("c_rem", K_WR, 8'h02, 8'h00, 2);
        expect_txn("c_don", K_KW, 8'h01, 8'h09, 2);
        expect_txn("c_dpl", K_RD, 8'h03, 8'h00, 2);

        // Divide by zero
        xin = 8'h2A; yin = 8'h00; start = 1'b1; ack = 1'b1;
        expect_txn("z_ack", K_KW, 8'h01, 8'h02, 2);
        ack = 1'b0;
        expect_txn("z_pol", K_RD, 8'h03, 8'h00, 2);
        expect_txn("z_rdx", K_RD, 8'h00, 8'h00, 2);
        start = 1'b0;
        expect_txn("z_rdy", K_RD, 8'h01, 8'h00, 2);
        expect_txn("z_cmp", K_KW, 8'h01, 8'h04, 2);
`ifdef DIV_ZERO_GUARD_EN
        expect_txn("z_quo", K_WR, 8'h00, 8'hFF, 2);
        expect_txn("z_rem", K_WR, 8'h02, 8'h2A, 2);
        expect_txn("z_don", K_KW, 8'h01, 8'h09, 2);
        expect_txn("z_dpl", K_RD, 8'h03, 8'h00, 2);
        // Launch a long divide (200 / 1) so reset lands inside COMPUTE
        xin = 8'hC8; yin = 8'h01; start = 1'b1; ack = 1'b1;
        expect_txn("r_ack", K_KW, 8'h01, 8'h02, 2);
        ack = 1'b0;
        expect_txn("r_pol", K_RD, 8'h03, 8'h00, 2);
        expect_txn("r_rdx", K_RD, 8'h00, 8'h00, 2);
        start = 1'b0;
        expect_txn("r_rdy", K_RD, 8'h01, 8'h00, 2);
        expect_txn("r_cmp", K_KW, 8'h01, 8'h04, 2);
`else
        wait_strobe(1000, cyc, s);
        check("z_silent", 32'(s), 32'd0);
`endif

        // Reset in the middle of COMPUTE, asserted between clock edges
        repeat (10) @(negedge board_clk);
        #2 Reset = 1'b1;
        #1 check_reset_values("reset_in_compute");
        @(negedge board_clk);
        Reset = 1'b0;
        expect_txn("r_ini", K_KW, 8'h01, 8'h02, 2);

        // Reset while the status strobe is high
        #1 Reset = 1'b1;
        #1 check_reset_values("reset_in_strobe");
        @(negedge board_clk);
        Reset = 1'b0;
        expect_txn("s_ini", K_KW, 8'h01, 8'h02, 2);
        expect_txn("s_pol", K_RD, 8'h03, 8'h00, 2);

        check("onehot_strobes", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
